// File: rtl/clock_ctrl_pkg.sv
// Shared encodings, field limits and default keycodes for the LED-fan clock controller.
// step_wrap() implements the +/-1 wrap used by both run-mode carries and set-mode edits.
package clock_ctrl_pkg;

   localparam logic [1:0] MODE_RUN   = 2'd0;
   localparam logic [1:0] MODE_SET_H = 2'd1;
   localparam logic [1:0] MODE_SET_M = 2'd2;
   localparam logic [1:0] MODE_SET_S = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN   = MODE_RUN,
      ST_SET_H = MODE_SET_H,
      ST_SET_M = MODE_SET_M,
      ST_SET_S = MODE_SET_S
   } mode_e;

   localparam logic [3:0] HOUR_MAX = 4'd11;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] SEC_MAX  = 6'd59;

   localparam logic [8:0] KEY_MODE_DEF = 9'h05A;
   localparam logic [8:0] KEY_UP_DEF   = 9'h01D;
   localparam logic [8:0] KEY_DOWN_DEF = 9'h01B;

   // Decrement from 0 selects the limit explicitly rather than relying on underflow.
   function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                            input logic up);
      if (up) return (v == max) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? max : v - 6'd1;
   endfunction

endpackage

// File: rtl/pulse_divider.sv
// Free-running modulo-DIV counter producing a one-cycle pulse at count DIV-1.
// clr or !en holds the count at 0 and suppresses the pulse.
module pulse_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic pulse_o
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] TC = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign pulse_o = en_i && !clr_i && (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i)  cnt_d = '0;
      else if (cnt_q == TC) cnt_d = '0;
      else                 cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/clock_time_controller.sv
// 12-hour timekeeper with keyboard set mode feeding the LED-fan display decoder.
//   state    | meaning
//   ST_RUN   | time advances on the 1 Hz tick, UP/DOWN ignored
//   ST_SET_H | hour edited, time frozen, blink active
//   ST_SET_M | minute edited
//   ST_SET_S | second edited; next MODE restarts the tick from 0
module clock_time_controller
   import clock_ctrl_pkg::*;
#(
   parameter int         CLK_HZ   = 100_000_000,
   parameter int         BLINK_HZ = 4,
   parameter logic [8:0] KEY_MODE = KEY_MODE_DEF,
   parameter logic [8:0] KEY_UP   = KEY_UP_DEF,
   parameter logic [8:0] KEY_DOWN = KEY_DOWN_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] key_down,
   input  logic [8:0]   last_change,
   input  logic         been_ready,
   output logic [3:0]   hour,
   output logic [5:0]   min,
   output logic [5:0]   sec,
   output logic [1:0]   field_sel,
   output logic         blink,
   output logic         sec_pulse
);

   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

   mode_e      state_q, state_d;
   logic [3:0] hour_q, hour_d;
   logic [5:0] min_q, min_d, sec_q, sec_d;
   logic       blink_q, blink_d, sec_pulse_q, sec_pulse_d;
   logic       key_ev, ev_mode, ev_up, ev_down, mode_chg, tick, blink_tgl;

   assign key_ev   = been_ready && key_down[last_change];
   assign ev_mode  = key_ev && (last_change == KEY_MODE);
   assign ev_up    = key_ev && (last_change == KEY_UP);
   assign ev_down  = key_ev && (last_change == KEY_DOWN);
   assign mode_chg = (state_d != state_q);

   pulse_divider #(.DIV(CLK_HZ)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (1'b0),
      .en_i    (state_q == ST_RUN),
      .pulse_o (tick)
   );

   pulse_divider #(.DIV(BLINK_DIV)) u_blink (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (mode_chg),
      .en_i    (state_q != ST_RUN),
      .pulse_o (blink_tgl)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ev_mode) begin
         case (state_q)
            ST_RUN:   state_d = ST_SET_H;
            ST_SET_H: state_d = ST_SET_M;
            ST_SET_M: state_d = ST_SET_S;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      sec_pulse_d = 1'b0;
      blink_d     = blink_q;
      if (state_q == ST_RUN) begin
         if (tick) begin
            sec_pulse_d = 1'b1;
            sec_d       = step_wrap(sec_q, SEC_MAX, 1'b1);
            if (sec_q == SEC_MAX) begin
               min_d = step_wrap(min_q, MIN_MAX, 1'b1);
               if (min_q == MIN_MAX)
                  hour_d = 4'(step_wrap({2'b00, hour_q}, {2'b00, HOUR_MAX}, 1'b1));
            end
         end
      end else if (ev_up || ev_down) begin
         case (state_q)
            ST_SET_H: hour_d = 4'(step_wrap({2'b00, hour_q}, {2'b00, HOUR_MAX}, ev_up));
            ST_SET_M: min_d  = step_wrap(min_q, MIN_MAX, ev_up);
            ST_SET_S: sec_d  = step_wrap(sec_q, SEC_MAX, ev_up);
            default: ;
         endcase
      end
      // Each newly entered field starts in the visible phase.
      if (mode_chg || state_d == ST_RUN) blink_d = 1'b0;
      else if (blink_tgl)                blink_d = ~blink_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hour_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         blink_q     <= 1'b0;
         sec_pulse_q <= 1'b0;
      end else begin
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         blink_q     <= blink_d;
         sec_pulse_q <= sec_pulse_d;
      end
   end

   assign hour      = hour_q;
   assign min       = min_q;
   assign sec       = sec_q;
   assign field_sel = state_q;
   assign blink     = blink_q;
   assign sec_pulse = sec_pulse_q;

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Timekeeping and configuration controller for the LED-fan analogue clock display.
- Produces the hour/min/sec values consumed by the fan's LED decoder.
- Runs a 12-hour clock from a 1 Hz tick divided from clk, and provides a keyboard-driven set mode (PS/2 key_down/last_change/been_ready interface) for editing each field.
- Sits between the keyboard decoder and the LED decoder. It configures the display datapath and never touches fanclk or LED timing.

Parameters:
- CLK_HZ, 100_000_000, clk frequency; the 1 Hz tick period in cycles.
- BLINK_HZ, 4, toggle rate of the blink output in set mode (toggle period CLK_HZ/(2*BLINK_HZ) cycles).
- KEY_MODE, 9'h05A, key code (Enter) that advances the mode.
- KEY_UP, 9'h01D, key code (W) that increments the selected field.
- KEY_DOWN, 9'h01B, key code (S) that decrements the selected field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- key_down  in  512  per-keycode held flags from the keyboard decoder
- last_change  in  9  keycode of the most recent make/break event
- been_ready  in  1  one-cycle strobe: last_change is valid
- hour  out  4  hours, 0..11 (0 displayed as 12)
- min  out  6  minutes, 0..59
- sec  out  6  seconds, 0..59
- field_sel  out  2  0=RUN, 1=hour, 2=min, 3=sec being edited
- blink  out  1  blink phase for the edited field; 0 in RUN
- sec_pulse  out  1  one-cycle pulse on each seconds increment in RUN

Behaviour:
- Reset (rst=0, async): hour=0, min=0, sec=0, field_sel=0 (RUN), blink=0, sec_pulse=0, tick counter=0, blink counter=0. All outputs are registered.
- Key event: key_ev = been_ready && key_down[last_change]. Break codes (key_down bit 0) are ignored. Keyboard typematic repeats produce repeated events, and each one is acted on.
- Only key_ev with last_change equal to KEY_MODE, KEY_UP or KEY_DOWN has any effect. All other codes are ignored.
- FSM states: RUN -> SET_H -> SET_M -> SET_S -> RUN. Each transition fires on key_ev with KEY_MODE. The state is the field_sel encoding.
- RUN, tick counter:
  - The tick counter counts 0..CLK_HZ-1.
  - At terminal count: the counter wraps to 0, sec increments, and sec_pulse=1 in that same cycle.
  - Carry chain, all in the same cycle: sec 59->0 carries into min; min 59->0 carries into hour; hour 11->0.
  - 11:59:59 becomes 0:00:00 in one cycle.
- RUN, keys: KEY_UP and KEY_DOWN are ignored.
- SET_x states:
  - The tick counter is held at 0, time is frozen, and sec_pulse=0.
  - KEY_UP adds 1 to the selected field; KEY_DOWN subtracts 1.
  - Wrap limits: hour wraps 11<->0; min and sec wrap 59<->0.
  - No carry into other fields.
- SET_S -> RUN: the tick counter restarts at 0, so the first increment occurs exactly CLK_HZ cycles after the transition.
- Simultaneous tick terminal count and KEY_MODE event in RUN: the time increment commits AND the state moves to SET_H in the same cycle.
- blink:
  - In SET_x, blink toggles every CLK_HZ/(2*BLINK_HZ) cycles.
  - The blink counter and blink reset to 0 on every state change, so each field starts visible-phase 0.
  - In RUN, blink=0 and the blink counter is held at 0.
- Reset asserted mid-edit: immediate return to RUN at 0:00:00. Partial edits are discarded.
- Width rules: field arithmetic uses the field width. Decrement from 0 is explicitly selected to the limit, never an underflowed value. Counters are sized $clog2(CLK_HZ).

Decomposition:
- Package clock_ctrl_pkg holds:
  - mode encoding constants: MODE_RUN=2'd0, MODE_SET_H=2'd1, MODE_SET_M=2'd2, MODE_SET_S=2'd3
  - field limits: HOUR_MAX=4'd11, MIN_MAX=6'd59, SEC_MAX=6'd59
  - default keycodes
- One sub-module, pulse_divider (parameter DIV, inputs clk/rst/clr/en, output one-cycle pulse at count DIV-1). Instantiated twice: the 1 Hz tick (DIV=CLK_HZ, en=RUN) and the blink toggle (DIV=CLK_HZ/(2*BLINK_HZ), en=!RUN, clr=state change).

Test Plan (CLK_HZ=10, BLINK_HZ=1 for simulation):
- Reset low for 3 cycles, then release and run 10 cycles -> outputs 0/0/0, field_sel=0; sec becomes 1 with sec_pulse=1 exactly on cycle 10 after release.
- Preload 11:59:59 via set mode, return to RUN, wait 10 cycles -> hour=0, min=0, sec=0 in a single cycle.
- In RUN, press KEY_MODE once, then KEY_DOWN twice -> field_sel=1, hour 0->11->10; sec and min unchanged over 50 cycles.
- Press KEY_MODE to SET_M and KEY_UP at min=59 -> min=0, hour unchanged. Blink toggles every 5 cycles and restarts at 0 on each mode change.
- Hold key_down[KEY_UP]=1 with been_ready=0 for 20 cycles; then send a break event (been_ready=1, key_down bit 0) -> no field change in either case.
- In SET_S with sec=30, drive rst=0 for 1 cycle asynchronously mid-cycle -> outputs immediately 0/0/0, field_sel=0, blink=0. KEY_MODE on the same cycle as the tick terminal count in RUN -> sec increments and field_sel=1 together.
